// File: rtl/cska_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready flow control and a global stall.
// Optional overflow output enabled by defining CSKA_OVF_EN.
module cska_pipe #(
  parameter int unsigned WIDTH  = 22,
  parameter int unsigned BLOCK  = 3,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef CSKA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int W          = int'(WIDTH);
  localparam int Blk        = int'(BLOCK);
  localparam int Stg        = int'(STAGES);
  localparam int NBlk       = (W + Blk - 1) / Blk;
  localparam int BlkPerStg  = (NBlk + Stg - 1) / Stg;
  localparam int BitsPerStg = BlkPerStg * Blk;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic             v_q [STAGES];
  logic             v_d [STAGES];
  logic             adv;

  assign adv = !(out_valid && !out_ready);

  always_comb begin : comb_stages
    logic [WIDTH-1:0] ta, tb, ts;
    logic             tc, tv, bc, pall, p;
    int               lo, hi;
    ta   = '0;
    tb   = '0;
    ts   = '0;
    tc   = 1'b0;
    tv   = 1'b0;
    bc   = 1'b0;
    pall = 1'b0;
    p    = 1'b0;
    lo   = 0;
    hi   = 0;
    for (int s = 0; s < Stg; s++) begin
      if (s == 0) begin
        ta = x;
        tb = sub ? ~y : y;
        ts = '0;
        tc = sub | cin;
        tv = in_valid;
      end else begin
        ta = a_q[s-1];
        tb = b_q[s-1];
        ts = s_q[s-1];
        tc = c_q[s-1];
        tv = v_q[s-1];
      end
      // Trailing stages may own no blocks and then act as plain delay registers.
      lo = s * BitsPerStg;
      hi = (s == Stg - 1) ? W : lo + BitsPerStg;
      if (lo > W) lo = W;
      if (hi > W) hi = W;
      bc   = tc;
      pall = 1'b1;
      for (int i = 0; i < W; i++) begin
        if (i >= lo && i < hi) begin
          if (i % Blk == 0) begin
            bc   = tc;
            pall = 1'b1;
          end
          p     = ta[i] ^ tb[i];
          ts[i] = p ^ tc;
          tc    = (ta[i] & tb[i]) | (p & tc);
          pall  = pall & p;
          // Skip path: all-propagate block forwards its carry-in directly.
          if ((i % Blk == Blk - 1) || (i == W - 1)) tc = tc | (pall & bc);
        end
      end
      a_d[s] = adv ? ta : a_q[s];
      b_d[s] = adv ? tb : b_q[s];
      s_d[s] = adv ? ts : s_q[s];
      c_d[s] = adv ? tc : c_q[s];
      v_d[s] = adv ? tv : v_q[s];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < Stg; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
        c_q[s] <= 1'b0;
        v_q[s] <= 1'b0;
      end
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[Stg-1];
  assign sum       = {c_q[Stg-1], s_q[Stg-1]};

`ifdef CSKA_OVF_EN
  // Carry into the MSB is recovered as p ^ s at that bit.
  assign ovf = a_q[Stg-1][W-1] ^ b_q[Stg-1][W-1] ^ s_q[Stg-1][W-1] ^ c_q[Stg-1];
`endif

endmodule

// File: tb/tb_cska_pipe.sv
// Directed checks for cska_pipe: reset, add/sub corners, stall, mid-flight reset, overflow,
// plus a short scoreboarded run with random out_ready.
module tb_cska_pipe;

  localparam int unsigned WIDTH  = 22;
  localparam int unsigned BLOCK  = 3;
  localparam int unsigned STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
`ifdef CSKA_OVF_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cska_pipe #(
    .WIDTH (WIDTH),
    .BLOCK (BLOCK),
    .STAGES(STAGES)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum)
`ifdef CSKA_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] ya,
                       input logic ci, input logic sb);
    in_valid = 1'b1;
    x        = xa;
    y        = ya;
    cin      = ci;
    sub      = sb;
  endtask

  // One isolated operation: accepted on the first edge, visible after the STAGES-th edge.
  task automatic run_one(input string tag, input logic [WIDTH-1:0] xa,
                         input logic [WIDTH-1:0] ya, input logic ci, input logic sb,
                         input logic [WIDTH:0] exp);
    drive(xa, ya, ci, sb);
    tick();
    in_valid = 1'b0;
    check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(sum), 64'(exp));
    tick();
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] ya,
                                           input logic ci, input logic sb);
    logic [WIDTH-1:0] yy;
    yy = sb ? ~ya : ya;
    return {1'b0, xa} + {1'b0, yy} + (WIDTH+1)'(sb ? 1'b1 : ci);
  endfunction

  logic [WIDTH:0] exp_q [$];
  logic [WIDTH:0] e;
  logic           pending;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    run_one("skip_chain", 22'h3FFFFF, 22'h000001, 1'b0, 1'b0, 23'h400000);
    run_one("sub_borrow", 22'd5, 22'd7, 1'b0, 1'b1, 23'h3FFFFE);
    run_one("sub_noborrow", 22'd7, 22'd5, 1'b1, 1'b1, 23'h400002);
    run_one("add_cin", 22'd1, 22'd2, 1'b1, 1'b0, 23'd4);
    run_one("max_max_cin", 22'h3FFFFF, 22'h3FFFFF, 1'b1, 1'b0, 23'h7FFFFF);
    run_one("zero_minus_zero", 22'd0, 22'd0, 1'b0, 1'b1, 23'h400000);
    run_one("mixed", 22'h2AAAAA, 22'h155555, 1'b0, 1'b0, 23'h3FFFFF);

    // Back-to-back with a 3-cycle downstream stall.
    drive(22'd1, 22'd1, 1'b0, 1'b0);
    tick();
    drive(22'd2, 22'd2, 1'b0, 1'b0);
    tick();
    check("b2b_first_valid", 64'(out_valid), 64'd1);
    check("b2b_first_sum", 64'(sum), 64'd2);
    out_ready = 1'b0;
    drive(22'd3, 22'd3, 1'b0, 1'b0);
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_sum_held", 64'(sum), 64'd2);
      check("stall_valid_held", 64'(out_valid), 64'd1);
      check("stall_in_ready_low", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("b2b_sum4", 64'(sum), 64'd4);
    drive(22'd4, 22'd4, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("b2b_sum6", 64'(sum), 64'd6);
    tick();
    check("b2b_sum8", 64'(sum), 64'd8);
    check("b2b_sum8_valid", 64'(out_valid), 64'd1);
    tick();
    check("b2b_drained", 64'(out_valid), 64'd0);

    // Reset with two results in flight.
    drive(22'd10, 22'd10, 1'b0, 1'b0);
    tick();
    drive(22'd20, 22'd20, 1'b0, 1'b0);
    tick();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    rst_n = 1'b1;
    tick();
    check("postrst_valid1", 64'(out_valid), 64'd0);
    tick();
    check("postrst_valid2", 64'(out_valid), 64'd0);
    run_one("postrst_new", 22'd9, 22'd9, 1'b0, 1'b0, 23'd18);

`ifdef CSKA_OVF_EN
    drive(22'h1FFFFF, 22'd1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    check("ovf_add_sum", 64'(sum), 64'h200000);
    check("ovf_add", 64'(ovf), 64'd1);
    drive(22'h200000, 22'd1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("ovf_sub", 64'(ovf), 64'd1);
    drive(22'd7, 22'd5, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("ovf_none", 64'(ovf), 64'd0);
    tick();
`endif

    // Scoreboarded run with random valid and out_ready.
    pending = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!pending) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        x        = WIDTH'($urandom);
        y        = WIDTH'($urandom);
        cin      = 1'($urandom);
        sub      = 1'($urandom);
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) exp_q.push_back(model(x, y, cin, sub));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected", 64'(sum), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("rand_sum", 64'(sum), 64'(e));
        end
      end
      pending = in_valid && !in_ready;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("drain_unexpected", 64'(sum), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("drain_sum", 64'(sum), 64'(e));
        end
      end
      @(posedge clk);
      #1;
    end
    check("rand_all_delivered", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
